alu_multiciclo: RTL and testbench

- Parametrised successor to the datapath's combinational ALU.
- Keeps the six single-cycle logic/arithmetic operations and their codes.
- Adds signed SLT, SLTU and an overflow flag.
- Adds iterative signed/unsigned multiply and divide with HI/LO registers, MFHI/MFLO reads, and a start/busy/done handshake so the multi-cycle control unit can stall on long operations.

---
 rtl/alu_pkg.sv | 28 ++
 rtl/alu_muldiv_iter.sv | 118 +++++++++++
 rtl/alu_multiciclo.sv | 143 ++++++++++++++
 tb/tb_alu_multiciclo.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcodes, FSM encoding and helpers for the multi-cycle ALU.
package alu_pkg;

    localparam logic [3:0] OP_AND   = 4'd0;
    localparam logic [3:0] OP_OR    = 4'd1;
    localparam logic [3:0] OP_ADD   = 4'd2;
    localparam logic [3:0] OP_MULTU = 4'd3;
    localparam logic [3:0] OP_MULT  = 4'd4;
    localparam logic [3:0] OP_DIVU  = 4'd5;
    localparam logic [3:0] OP_SUB   = 4'd6;
    localparam logic [3:0] OP_SLT   = 4'd7;
    localparam logic [3:0] OP_SLTU  = 4'd8;
    localparam logic [3:0] OP_DIV   = 4'd9;
    localparam logic [3:0] OP_MFHI  = 4'd10;
    localparam logic [3:0] OP_MFLO  = 4'd11;
    localparam logic [3:0] OP_NOR   = 4'd12;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    function automatic logic is_multiciclo(input logic [3:0] op);
        return (op == OP_MULTU) || (op == OP_MULT) || (op == OP_DIVU) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative multiply / restoring divide, one bit per cycle, with sign fix applied
// combinationally on the final accumulator/shift-register contents.
module alu_muldiv_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             fin
);

    logic [WIDTH-1:0]   acc_q, acc_d, sr_q, sr_d, opb_q, opb_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               active_q, active_d, is_div_q, is_div_d;
    logic               neg_hi_q, neg_hi_d, neg_lo_q, neg_lo_d;
    logic               is_div, is_signed, a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     add_sum, sub_trial;
    logic [2*WIDTH-1:0] prod_fix;

    always_comb begin
        is_div    = (op == OP_DIVU) || (op == OP_DIV);
        is_signed = (op == OP_MULT) || (op == OP_DIV);
        a_neg     = is_signed && a[WIDTH-1];
        b_neg     = is_signed && b[WIDTH-1];
        a_mag     = a_neg ? -a : a;
        b_mag     = b_neg ? -b : b;
        add_sum   = {1'b0, acc_q} + {1'b0, opb_q};
        sub_trial = {acc_q, sr_q[WIDTH-1]} - {1'b0, opb_q};
        fin       = active_q && (cnt_q == CNT_W'(WIDTH - 1));

        acc_d    = acc_q;
        sr_d     = sr_q;
        opb_d    = opb_q;
        cnt_d    = cnt_q;
        active_d = active_q;
        is_div_d = is_div_q;
        neg_hi_d = neg_hi_q;
        neg_lo_d = neg_lo_q;

        if (load) begin
            // Divide: sr holds the dividend/quotient; multiply: sr holds the multiplier.
            acc_d    = '0;
            sr_d     = is_div ? a_mag : b_mag;
            opb_d    = is_div ? b_mag : a_mag;
            cnt_d    = '0;
            active_d = 1'b1;
            is_div_d = is_div;
            neg_lo_d = a_neg ^ b_neg;
            neg_hi_d = is_div ? a_neg : (a_neg ^ b_neg);
            if (is_div && (b == '0)) begin
                acc_d    = a;
                sr_d     = '1;
                active_d = 1'b0;
                neg_lo_d = 1'b0;
                neg_hi_d = 1'b0;
            end
        end else if (active_q) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (fin) begin
                active_d = 1'b0;
            end
            if (is_div_q) begin
                if (!sub_trial[WIDTH]) begin
                    acc_d = sub_trial[WIDTH-1:0];
                    sr_d  = {sr_q[WIDTH-2:0], 1'b1};
                end else begin
                    acc_d = {acc_q[WIDTH-2:0], sr_q[WIDTH-1]};
                    sr_d  = {sr_q[WIDTH-2:0], 1'b0};
                end
            end else if (sr_q[0]) begin
                {acc_d, sr_d} = {add_sum, sr_q[WIDTH-1:1]};
            end else begin
                {acc_d, sr_d} = {1'b0, acc_q, sr_q[WIDTH-1:1]};
            end
        end

        prod_fix = neg_lo_q ? -{acc_q, sr_q} : {acc_q, sr_q};
        if (is_div_q) begin
            hi = neg_hi_q ? -acc_q : acc_q;
            lo = neg_lo_q ? -sr_q : sr_q;
        end else begin
            hi = prod_fix[2*WIDTH-1:WIDTH];
            lo = prod_fix[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q    <= '0;
            sr_q     <= '0;
            opb_q    <= '0;
            cnt_q    <= '0;
            active_q <= 1'b0;
            is_div_q <= 1'b0;
            neg_hi_q <= 1'b0;
            neg_lo_q <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            sr_q     <= sr_d;
            opb_q    <= opb_d;
            cnt_q    <= cnt_d;
            active_q <= active_d;
            is_div_q <= is_div_d;
            neg_hi_q <= neg_hi_d;
            neg_lo_q <= neg_lo_d;
        end
    end

endmodule

// File: rtl/alu_multiciclo.sv
// Multi-cycle ALU: single-cycle logic/arithmetic ops plus iterative mul/div with HI/LO,
// controlled by a start/busy/done handshake.
module alu_multiciclo
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       controlOut,
    input  logic [WIDTH-1:0] dadosLe1,
    input  logic [WIDTH-1:0] muxOut,
    output logic [WIDTH-1:0] aluOut,
    output logic             zr,
    output logic             overflow,
    output logic             div_zero,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    state_t           state_q, state_d;
    logic [WIDTH-1:0] alu_q, alu_d, hi_q, hi_d, lo_q, lo_d;
    logic             ovf_q, ovf_d, dz_q, dz_d, done_q, done_d;
    logic             load, iter_fin;
    logic [WIDTH-1:0] iter_hi, iter_lo, sum, diff;

    alu_muldiv_iter #(
        .WIDTH(WIDTH),
        .CNT_W(CNT_W)
    ) u_iter (
        .clk  (clk),
        .reset(reset),
        .load (load),
        .op   (controlOut),
        .a    (dadosLe1),
        .b    (muxOut),
        .hi   (iter_hi),
        .lo   (iter_lo),
        .fin  (iter_fin)
    );

    always_comb begin
        state_d = state_q;
        alu_d   = alu_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        ovf_d   = ovf_q;
        dz_d    = dz_q;
        done_d  = 1'b0;
        sum     = dadosLe1 + muxOut;
        diff    = dadosLe1 - muxOut;
        load    = (state_q == IDLE) && start && is_multiciclo(controlOut);

        case (state_q)
            IDLE: begin
                if (start && is_multiciclo(controlOut)) begin
                    state_d = CALC;
                    if ((controlOut == OP_DIVU) || (controlOut == OP_DIV)) begin
                        dz_d = (muxOut == '0);
                        if (muxOut == '0) begin
                            state_d = FIX;
                            ovf_d   = 1'b0;
                        end else if (controlOut == OP_DIV) begin
                            ovf_d = (dadosLe1 == MOST_NEG) && (muxOut == '1);
                        end
                    end
                end else if (start) begin
                    done_d = 1'b1;
                    case (controlOut)
                        OP_AND:  alu_d = dadosLe1 & muxOut;
                        OP_OR:   alu_d = dadosLe1 | muxOut;
                        OP_NOR:  alu_d = ~(dadosLe1 | muxOut);
                        OP_ADD: begin
                            alu_d = sum;
                            ovf_d = (dadosLe1[WIDTH-1] == muxOut[WIDTH-1]) &&
                                    (sum[WIDTH-1] != dadosLe1[WIDTH-1]);
                        end
                        OP_SUB: begin
                            alu_d = diff;
                            ovf_d = (dadosLe1[WIDTH-1] != muxOut[WIDTH-1]) &&
                                    (diff[WIDTH-1] != dadosLe1[WIDTH-1]);
                        end
                        OP_SLT:  alu_d = {{(WIDTH-1){1'b0}}, $signed(dadosLe1) < $signed(muxOut)};
                        OP_SLTU: alu_d = {{(WIDTH-1){1'b0}}, dadosLe1 < muxOut};
                        OP_MFHI: alu_d = hi_q;
                        OP_MFLO: alu_d = lo_q;
                        default: alu_d = '0;
                    endcase
                end
            end
            // fin is high during the last iteration, so FIX sees final values.
            CALC: begin
                if (iter_fin) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                state_d = IDLE;
                hi_d    = iter_hi;
                lo_d    = iter_lo;
                alu_d   = iter_lo;
                done_d  = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            alu_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            ovf_q   <= 1'b0;
            dz_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            alu_q   <= alu_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            ovf_q   <= ovf_d;
            dz_q    <= dz_d;
            done_q  <= done_d;
        end
    end

    assign aluOut   = alu_q;
    assign zr       = (alu_q == '0);
    assign overflow = ovf_q;
    assign div_zero = dz_q;
    assign busy     = (state_q == CALC) || (state_q == FIX);
    assign done     = done_q;
    assign hi       = hi_q;
    assign lo       = lo_q;

endmodule

// File: tb/tb_alu_multiciclo.sv
// Directed bench for alu_multiciclo with an arithmetic reference model checked every cycle.
module tb_alu_multiciclo;

    localparam int W = 32;

    localparam logic [3:0] C_AND = 4'd0,  C_OR = 4'd1,  C_ADD = 4'd2,  C_MULTU = 4'd3;
    localparam logic [3:0] C_MULT = 4'd4, C_DIVU = 4'd5, C_SUB = 4'd6, C_SLT = 4'd7;
    localparam logic [3:0] C_SLTU = 4'd8, C_DIV = 4'd9, C_MFHI = 4'd10, C_MFLO = 4'd11;
    localparam logic [3:0] C_NOR = 4'd12;

    logic         clk = 1'b0;
    logic         reset, start;
    logic [3:0]   ctrl;
    logic [W-1:0] opa, opb;
    logic [W-1:0] aluOut, hi, lo;
    logic         zr, overflow, div_zero, busy, done;

    alu_multiciclo #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .controlOut(ctrl),
        .dadosLe1  (opa),
        .muxOut    (opb),
        .aluOut    (aluOut),
        .zr        (zr),
        .overflow  (overflow),
        .div_zero  (div_zero),
        .busy      (busy),
        .done      (done),
        .hi        (hi),
        .lo        (lo)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    logic chk_en = 1'b0;
    logic exp_busy = 1'b0, exp_done = 1'b0;
    logic [W-1:0] m_alu = '0, m_hi = '0, m_lo = '0;
    logic m_ovf = 1'b0, m_dz = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference: plain integer arithmetic on 64-bit values.
    task automatic model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         output int lat, output logic [W-1:0] e_alu, output logic [W-1:0] e_hi,
                         output logic [W-1:0] e_lo, output logic e_ovf, output logic e_dz);
        longint sa, sb, r, q;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        e_alu = m_alu; e_hi = m_hi; e_lo = m_lo; e_ovf = m_ovf; e_dz = m_dz; lat = 0;
        case (op)
            C_AND:  e_alu = a & b;
            C_OR:   e_alu = a | b;
            C_NOR:  e_alu = ~(a | b);
            C_ADD, C_SUB: begin
                r = (op == C_ADD) ? sa + sb : sa - sb;
                e_alu = r[W-1:0];
                e_ovf = (r != longint'($signed(r[W-1:0])));
            end
            C_SLT:  e_alu = (sa < sb) ? W'(1) : W'(0);
            C_SLTU: e_alu = (a < b) ? W'(1) : W'(0);
            C_MFHI: e_alu = m_hi;
            C_MFLO: e_alu = m_lo;
            C_MULTU, C_MULT: begin
                if (op == C_MULT) begin
                    r = sa * sb;
                    p = r;
                end else begin
                    p = 64'(a) * 64'(b);
                end
                e_hi = p[2*W-1:W]; e_lo = p[W-1:0]; e_alu = e_lo; lat = W + 1;
            end
            C_DIVU, C_DIV: begin
                if (b == '0) begin
                    e_lo = '1; e_hi = a; e_dz = 1'b1; e_ovf = 1'b0; lat = 1;
                end else begin
                    e_dz = 1'b0; lat = W + 1;
                    if (op == C_DIVU) begin
                        e_lo = a / b; e_hi = a % b;
                    end else begin
                        q = sa / sb; r = sa % sb;
                        e_lo = q[W-1:0]; e_hi = r[W-1:0];
                        e_ovf = (q != longint'($signed(q[W-1:0])));
                    end
                end
                e_alu = e_lo;
            end
            default: e_alu = '0;
        endcase
    endtask

    // Issue one op at posedge+2 and track it until done (or until an abort by reset).
    task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input int poke_at, input int abort_at);
        int lat;
        logic [W-1:0] e_alu, e_hi, e_lo;
        logic e_ovf, e_dz;
        model(op, a, b, lat, e_alu, e_hi, e_lo, e_ovf, e_dz);
        ctrl = op; opa = a; opb = b; start = 1'b1;
        for (int k = 0; k <= lat; k++) begin
            @(posedge clk); #2;
            start = 1'b0;
            exp_busy = (k < lat);
            exp_done = (k == lat);
            if (k == lat) begin
                m_alu = e_alu; m_hi = e_hi; m_lo = e_lo; m_ovf = e_ovf; m_dz = e_dz;
                $display("op=%0d a=%h b=%h -> alu=%h hi=%h lo=%h ovf=%0b dz=%0b lat=%0d",
                         op, a, b, e_alu, e_hi, e_lo, e_ovf, e_dz, lat + 1);
            end else begin
                ctrl = 4'($urandom); opa = W'($urandom); opb = W'($urandom);
                if (k == poke_at) begin
                    start = 1'b1; ctrl = C_ADD;
                end
                if (k == abort_at) begin
                    reset = 1'b1;
                    @(posedge clk); #2;
                    reset = 1'b0;
                    m_alu = '0; m_hi = '0; m_lo = '0; m_ovf = 1'b0; m_dz = 1'b0;
                    exp_busy = 1'b0; exp_done = 1'b0;
                    $display("op=%0d a=%h b=%h aborted by reset after %0d cycles", op, a, b, k + 1);
                    return;
                end
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #2;
            start = 1'b0;
            exp_done = 1'b0;
            exp_busy = 1'b0;
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", busy, exp_busy);
            check("done", done, exp_done);
            if (!exp_busy) begin
                check("aluOut", aluOut, m_alu);
                check("zr", zr, m_alu == '0);
                check("hi", hi, m_hi);
                check("lo", lo, m_lo);
                check("overflow", overflow, m_ovf);
                check("div_zero", div_zero, m_dz);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; start = 1'b0; ctrl = '0; opa = '0; opb = '0;
        @(posedge clk); #2;
        reset = 1'b0;
        chk_en = 1'b1;
        check("rst_alu", aluOut, 0);
        check("rst_zr", zr, 1);
        check("rst_busy", busy, 0);
        idle(1);

        run_op(C_ADD, 32'h7FFF_FFFF, 32'h1, -1, -1);
        check("lit_add_alu", aluOut, 32'h8000_0000);
        check("lit_add_ovf", overflow, 1);
        idle(1);
        run_op(C_SLT, 32'hFFFF_FFFF, 32'h1, -1, -1);
        check("lit_slt", aluOut, 1);
        run_op(C_SLTU, 32'hFFFF_FFFF, 32'h1, -1, -1);
        check("lit_sltu", aluOut, 0);
        check("lit_sltu_zr", zr, 1);
        run_op(C_AND, 32'hF0F0_1234, 32'h0FF0_FF00, -1, -1);
        run_op(C_OR,  32'hF0F0_1234, 32'h0FF0_FF00, -1, -1);
        run_op(C_NOR, 32'hF0F0_1234, 32'h0FF0_FF00, -1, -1);
        run_op(C_SUB, 32'h8000_0000, 32'h1, -1, -1);
        run_op(C_SUB, 32'h5, 32'h7, -1, -1);
        run_op(4'd13, 32'h5, 32'h7, -1, -1);
        idle(2);

        run_op(C_MULT, 32'hFFFF_FFFD, 32'h7, -1, -1);
        check("lit_mult_hi", hi, 32'hFFFF_FFFF);
        check("lit_mult_lo", lo, 32'hFFFF_FFEB);
        check("lit_mult_alu", aluOut, 32'hFFFF_FFEB);
        idle(1);
        run_op(C_MFHI, 32'h0, 32'h0, -1, -1);
        check("lit_mfhi", aluOut, 32'hFFFF_FFFF);
        run_op(C_MFLO, 32'h0, 32'h0, -1, -1);
        idle(1);

        run_op(C_DIVU, 32'h7, 32'h0, -1, -1);
        check("lit_divu0_lo", lo, 32'hFFFF_FFFF);
        check("lit_divu0_hi", hi, 32'h7);
        check("lit_divu0_dz", div_zero, 1);
        idle(1);
        run_op(C_DIV, 32'hFFFF_FFF9, 32'h2, -1, -1);
        check("lit_div_lo", lo, 32'hFFFF_FFFD);
        check("lit_div_hi", hi, 32'hFFFF_FFFF);
        idle(1);
        run_op(C_DIV, 32'h8000_0000, 32'hFFFF_FFFF, -1, -1);
        check("lit_divovf_lo", lo, 32'h8000_0000);
        check("lit_divovf_ovf", overflow, 1);
        run_op(C_DIV, 32'h64, 32'hFFFF_FFF9, -1, -1);
        run_op(C_DIVU, 32'hDEAD_BEEF, 32'h1234, -1, -1);
        run_op(C_DIV, 32'h1234_5678, 32'h0, -1, -1);
        idle(1);

        run_op(C_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 10, -1);
        check("lit_multu_hi", hi, 32'hFFFF_FFFE);
        check("lit_multu_lo", lo, 32'h1);
        run_op(C_ADD, 32'h2, 32'h3, -1, -1);
        check("lit_chain_add", aluOut, 32'h5);
        run_op(C_MULT, 32'h8000_0000, 32'h8000_0000, -1, -1);
        idle(1);

        run_op(C_DIVU, 32'h1000, 32'h3, -1, 14);
        check("lit_abort_busy", busy, 0);
        check("lit_abort_hi", hi, 0);
        check("lit_abort_lo", lo, 0);
        check("lit_abort_zr", zr, 1);
        idle(3);
        run_op(C_ADD, 32'h10, 32'h20, -1, -1);
        idle(2);

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
